// File: rtl/splitter_pkg.sv
// Shared definitions for the two-layer splitter: lane count, lane index type
// and the sort-key extraction helper.
package splitter_pkg;

   localparam int NUM_LANES  = 4;
   localparam int LANE_IDX_W = 2;
   localparam int KEY_MAX_W  = 32;

   typedef logic [LANE_IDX_W-1:0] lane_idx_t;

   // Returns word[msb:lsb] right-aligned; callers truncate to the real key width.
   function automatic logic [KEY_MAX_W-1:0] extract_key(input logic [KEY_MAX_W-1:0] word,
                                                        input int msb,
                                                        input int lsb);
      logic [KEY_MAX_W-1:0] mask;
      mask = (KEY_MAX_W'(1) << (msb - lsb + 1)) - KEY_MAX_W'(1);
      return (word >> lsb) & mask;
   endfunction

endpackage

// File: rtl/splitter_lane_fifo.sv
// First-word-fall-through lane FIFO. Pointers carry one extra wrap bit;
// the head output holds the last popped word while the FIFO is empty.
module splitter_lane_fifo #(
   parameter int DATA_WIDTH  = 12,
   parameter int FIFO_ADDR_W = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << FIFO_ADDR_W;

   logic [FIFO_ADDR_W:0]  wptr_q, wptr_d;
   logic [FIFO_ADDR_W:0]  rptr_q, rptr_d;
   logic [DATA_WIDTH-1:0] last_q, last_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic                  do_push, do_pop;

   always_comb begin
      empty   = (wptr_q == rptr_q);
      full    = ((wptr_q ^ rptr_q) == {1'b1, {FIFO_ADDR_W{1'b0}}});
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      wptr_d  = wptr_q + (FIFO_ADDR_W+1)'(do_push);
      rptr_d  = rptr_q + (FIFO_ADDR_W+1)'(do_pop);
      mem_d   = mem_q;
      if (do_push) mem_d[wptr_q[FIFO_ADDR_W-1:0]] = din;
      last_d  = do_pop ? mem_q[rptr_q[FIFO_ADDR_W-1:0]] : last_q;
      dout    = empty ? last_q : mem_q[rptr_q[FIFO_ADDR_W-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         last_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         last_q <= last_d;
      end
   end

   // NOTE: storage is not reset; a slot is only ever read after it has been written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/splitter2layer.sv
// Splitter: routes the merged tagged stream into four FWFT lane FIFOs.
// Optional per-lane sort-order checking is enabled by SPLITTER_ORDER_CHECK_EN.
module splitter2layer
   import splitter_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int ACTIVE_MSB  = 11,
   parameter int ACTIVE_LSB  = 6,
   parameter int FIFO_ADDR_W = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  vin,
   input  logic [1:0]            input_index,
   output logic                  outread,
   output logic [DATA_WIDTH-1:0] out1,
   output logic [DATA_WIDTH-1:0] out2,
   output logic [DATA_WIDTH-1:0] out3,
   output logic [DATA_WIDTH-1:0] out4,
   output logic                  vout1,
   output logic                  vout2,
   output logic                  vout3,
   output logic                  vout4,
   input  logic                  inRead1,
   input  logic                  inRead2,
   input  logic                  inRead3,
   input  logic                  inRead4,
   output logic [3:0]            order_err
);

   lane_idx_t             lane;
   logic [NUM_LANES-1:0]  rd, push, pop, full, empty;
   logic [DATA_WIDTH-1:0] dout [NUM_LANES];

   // A full destination stalls the whole stream, even if that lane pops this cycle.
   always_comb begin
      lane    = input_index;
      rd      = {inRead4, inRead3, inRead2, inRead1};
      outread = en & reset & vin & ~full[lane];
      for (int k = 0; k < NUM_LANES; k++) begin
         push[k] = outread & (lane == lane_idx_t'(k));
         pop[k]  = en & ~empty[k] & rd[k];
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      splitter_lane_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_ADDR_W(FIFO_ADDR_W)
      ) u_fifo (
         .clk  (clk),
         .reset(reset),
         .push (push[g]),
         .pop  (pop[g]),
         .din  (in),
         .dout (dout[g]),
         .full (full[g]),
         .empty(empty[g])
      );
   end

   assign out1  = dout[0];
   assign out2  = dout[1];
   assign out3  = dout[2];
   assign out4  = dout[3];
   assign vout1 = ~empty[0];
   assign vout2 = ~empty[1];
   assign vout3 = ~empty[2];
   assign vout4 = ~empty[3];

`ifdef SPLITTER_ORDER_CHECK_EN
   localparam int KEY_W = ACTIVE_MSB - ACTIVE_LSB + 1;

   logic [KEY_W-1:0]     key_in;
   logic [KEY_W-1:0]     last_key_q [NUM_LANES];
   logic [KEY_W-1:0]     last_key_d [NUM_LANES];
   logic [NUM_LANES-1:0] err_q, err_d;

   // Keys clear to zero, so the first push after reset can never compare lower.
   always_comb begin
      key_in     = KEY_W'(extract_key(KEY_MAX_W'(in), ACTIVE_MSB, ACTIVE_LSB));
      last_key_d = last_key_q;
      err_d      = err_q;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (push[k]) begin
            if (key_in < last_key_q[k]) err_d[k] = 1'b1;
            last_key_d[k] = key_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < NUM_LANES; k++) last_key_q[k] <= '0;
         err_q <= '0;
      end else begin
         last_key_q <= last_key_d;
         err_q      <= err_d;
      end
   end

   assign order_err = err_q;
`else
   assign order_err = 4'b0000;
`endif

endmodule

// File: tb/tb_splitter2layer.sv
// Scoreboard bench for splitter2layer: per-lane expected queues filled by the
// driver, drained and compared by an independent monitor.
module tb_splitter2layer;

   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          en = 1'b0;
   logic          vin = 1'b0;
   logic [1:0]    idx = '0;
   logic [DW-1:0] in_w = '0;
   logic [3:0]    rd = '0;

   wire           outread;
   wire [DW-1:0]  out1, out2, out3, out4;
   wire           vout1, vout2, vout3, vout4;
   wire [3:0]     order_err;

   wire [3:0]     vout_v = {vout4, vout3, vout2, vout1};
   wire [DW-1:0]  dut_out [4];
   assign dut_out[0] = out1;
   assign dut_out[1] = out2;
   assign dut_out[2] = out3;
   assign dut_out[3] = out4;

   always #5 clk = ~clk;

   splitter2layer dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .in         (in_w),
      .vin        (vin),
      .input_index(idx),
      .outread    (outread),
      .out1       (out1),
      .out2       (out2),
      .out3       (out3),
      .out4       (out4),
      .vout1      (vout1),
      .vout2      (vout2),
      .vout3      (vout3),
      .vout4      (vout4),
      .inRead1    (rd[0]),
      .inRead2    (rd[1]),
      .inRead3    (rd[2]),
      .inRead4    (rd[3]),
      .order_err  (order_err)
   );

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q [4][$];
   logic [5:0]    last_key [4];
   logic [3:0]    exp_err = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model decides acceptance from its own lane occupancy.
   task automatic cycle(input logic r, input logic e, input logic v, input logic [1:0] i,
                        input logic [DW-1:0] d, input logic [3:0] rdv);
      logic       exp_or;
      logic [3:0] popf;
      @(negedge clk);
      reset = r; en = e; vin = v; idx = i; in_w = d; rd = rdv;
      #2;
      exp_or = r & e & v & (exp_q[i].size() < 4);
      check("outread", outread, exp_or);
      @(posedge clk);
      if (!r) begin
         for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_key[k] = '0;
         end
         exp_err = '0;
      end else begin
         for (int k = 0; k < 4; k++) popf[k] = e & rdv[k] & (exp_q[k].size() > 0);
         if (exp_or) begin
            exp_q[i].push_back(d);
`ifdef SPLITTER_ORDER_CHECK_EN
            if (d[11:6] < last_key[i]) exp_err[i] = 1'b1;
            last_key[i] = d[11:6];
`endif
         end
         for (int k = 0; k < 4; k++) if (popf[k]) void'(exp_q[k].pop_front());
      end
   endtask

   task automatic idle(input int n, input logic [3:0] rdv);
      for (int j = 0; j < n; j++) cycle(1'b1, 1'b1, 1'b0, 2'd0, '0, rdv);
   endtask

   // Monitor: compares lane valids, heads and error flags against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         for (int k = 0; k < 4; k++) begin
            check($sformatf("vout%0d", k + 1), vout_v[k], exp_q[k].size() != 0);
            if (exp_q[k].size() != 0)
               check($sformatf("out%0d", k + 1), dut_out[k], exp_q[k][0]);
         end
         check("order_err", order_err, exp_err);
      end
   end

   initial begin
      for (int k = 0; k < 4; k++) last_key[k] = '0;

      // Reset held with a valid word waiting upstream.
      for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, 1'b1, 2'd0, 12'h041, 4'h0);
      @(negedge clk); #3;
      check("rst_out1", out1, 0);
      check("rst_out4", out4, 0);
      check("rst_vout", vout_v, 0);

      // Basic routing to each lane.
      cycle(1'b1, 1'b1, 1'b1, 2'd0, 12'h041, 4'h0);
      cycle(1'b1, 1'b1, 1'b1, 2'd1, 12'h082, 4'h0);
      cycle(1'b1, 1'b1, 1'b1, 2'd2, 12'h0C3, 4'h0);
      cycle(1'b1, 1'b1, 1'b1, 2'd3, 12'h104, 4'h0);
      idle(1, 4'h0);
      @(negedge clk); #3;
      check("route_out1", out1, 12'h041);
      check("route_out2", out2, 12'h082);
      check("route_out3", out3, 12'h0C3);
      check("route_out4", out4, 12'h104);
      idle(3, 4'hF);

      // Fill lane 0, stall the fifth word, free one slot, then accept it.
      for (int n = 0; n < 5; n++) cycle(1'b1, 1'b1, 1'b1, 2'd0, 12'h100 + 12'(n), 4'h0);
      cycle(1'b1, 1'b1, 1'b1, 2'd0, 12'h104, 4'h1);
      cycle(1'b1, 1'b1, 1'b1, 2'd0, 12'h104, 4'h0);
      idle(6, 4'hF);

      // Simultaneous push and pop on lane 2.
      cycle(1'b1, 1'b1, 1'b1, 2'd2, 12'h201, 4'h0);
      cycle(1'b1, 1'b1, 1'b1, 2'd2, 12'h202, 4'h0);
      cycle(1'b1, 1'b1, 1'b1, 2'd2, 12'h203, 4'h4);
      idle(4, 4'h4);

      // Pointer wrap on lane 3 with its reader always ready.
      for (int n = 0; n < 20; n++) cycle(1'b1, 1'b1, 1'b1, 2'd3, 12'h300 + 12'(n), 4'h8);
      idle(3, 4'hF);

      // Descending keys on lane 1, flag persistence, then reset.
      cycle(1'b1, 1'b1, 1'b1, 2'd1, 12'(5 << 6), 4'h0);
      cycle(1'b1, 1'b1, 1'b1, 2'd1, 12'(3 << 6), 4'h0);
      idle(10, 4'h0);
      @(negedge clk); #3;
`ifdef SPLITTER_ORDER_CHECK_EN
      check("order_sticky", order_err, 4'b0010);
`else
      check("order_sticky", order_err, 4'b0000);
`endif
      cycle(1'b0, 1'b1, 1'b0, 2'd0, '0, 4'h0);
      idle(1, 4'h0);

      // Randomized traffic with occasional stalls on en and mid-stream resets.
      for (int n = 0; n < 400; n++)
         cycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               12'($urandom), 4'($urandom));
      idle(8, 4'hF);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/splitter2layer.md
Name: splitter2layer

Overview:
- Inverse of the two-layer 4-to-1 sorted merger: consumes the merged stream plus its 2-bit `input_index` tag and routes each word back to one of four output lanes.
- Each lane has a small first-word-fall-through (FWFT) FIFO. Lanes drain independently under per-lane read strobes.
- Sits at the receiving end of a merged link, in front of per-source consumers. Uses the same valid/read handshake as the merger.

Parameters:
- DATA_WIDTH, 12, payload width per word (tag excluded).
- ACTIVE_MSB, 11, MSB of the sort-key field inside the payload.
- ACTIVE_LSB, 6, LSB of the sort-key field inside the payload.
- FIFO_ADDR_W, 2, log2 of per-lane FIFO depth (default depth 4).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  global enable; when low, all state holds.
- in  input  DATA_WIDTH  merged payload.
- vin  input  1  upstream has a valid word on `in`/`input_index`.
- input_index  input  2  destination lane of the current word.
- outread  output  1  pop strobe to upstream; word accepted this cycle.
- out1..out4  output  DATA_WIDTH each  head-of-FIFO payload for lanes 0..3.
- vout1..vout4  output  1 each  lane FIFO non-empty.
- inRead1..inRead4  input  1 each  downstream pops the lane head this cycle.
- order_err  output  4  sticky per-lane sort-order violation flags (see Optional Feature).

Behaviour:
- Reset (reset==0 at clk edge):
  - all FIFO pointers and counts go to 0;
  - vout1..4=0, out1..4=0, outread=0 (combinational, forced 0 during reset), order_err=0.
- Accept rule:
  - outread = en & reset & vin & ~full[input_index].
  - This is a combinational path from vin/input_index to outread, matching the merger's read semantics.
  - When outread=1, the word is written to lane input_index at that clk edge.
- Full lane blocks the input even if that lane pops in the same cycle (conservative, no bypass).
- Head-of-line blocking: a word for a full lane stalls the whole stream, including words for other lanes. This preserves global order.
- Pop rule: lane k pops when en & vout_k & inRead_k. An inRead_k with vout_k=0 is ignored and no underflow occurs.
- Latency: a word accepted at edge N appears on out_k with vout_k=1 after edge N (one cycle, FWFT). Out_k holds its value while vout_k=1 and there is no pop.
- Simultaneous push and pop on the same non-full lane: count is unchanged, both pointers advance, and data integrity is kept.
- Pointers are FIFO_ADDR_W+1 bits wide. Wrap-around is modulo 2^FIFO_ADDR_W. full = (wptr^rptr) == {1'b1, 0...}.
- When vout_k=0, out_k is held at its last value (no X). The bench checks out_k only when vout_k=1.
- en=0: no push, no pop, outread=0, pointers and flags frozen. Outputs still reflect current FIFO heads.
- Reset mid-stream: all lanes are flushed in one cycle. Upstream sees outread=0 and retains its word.

Optional Feature:
- Macro: SPLITTER_ORDER_CHECK_EN.
- Defined:
  - each lane keeps a register of the last pushed key in[ACTIVE_MSB:ACTIVE_LSB], cleared at reset;
  - on a push whose key is less than the lane's last key (unsigned compare), order_err[k] is set and stays set until reset;
  - the first push after reset never flags.
- Undefined: order_err is tied to 4'b0000 and no key registers are synthesised.

Decomposition:
- Shared package splitter_pkg holds:
  - NUM_LANES=4, LANE_IDX_W=2;
  - the key-extract function (slice ACTIVE_MSB:ACTIVE_LSB);
  - the lane-index typedef.
- One natural sub-module, splitter_lane_fifo: parameterised FWFT FIFO (DATA_WIDTH, FIFO_ADDR_W) with push/pop/full/empty. It is instantiated four times.
- The top level handles demux decode, outread generation and the optional order check.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles with vin=1 -> outread=0, vout1..4=0, order_err=0.
- Basic routing: push words 0x041 (idx 0), 0x082 (idx 1), 0x0C3 (idx 2), 0x104 (idx 3) on consecutive cycles with no inRead -> each vout_k rises one cycle after its push, and out1..4 equal 0x041, 0x082, 0x0C3, 0x104.
- Full and head-of-line stall: push 5 words to lane 0 with depth 4 -> the 5th is held (outread=0). Then assert inRead1 for one cycle -> the 5th word is accepted on the following cycle.
- Simultaneous push and pop: lane 2 holds 2 words; push to lane 2 while inRead3=1 -> count stays 2 and pop order is FIFO-correct.
- Pointer wrap: stream 20 words to lane 3 with inRead4 held high -> outputs emerge in order with no loss or duplicate.
- Optional order check (SPLITTER_ORDER_CHECK_EN defined): lane 1 receives keys 5 then 3 -> order_err=4'b0010 after the second push, still set 10 cycles later, cleared by reset.
